// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that shares the write port of the asynchronous FIFO
// among NREQ requesters in the write clock domain. One beat per cycle is
// accepted from the current owner while full is low. grant/wen/wdata are
// combinational so a rising full stalls the port in the same cycle.
//
// Optional feature macro: FIFO_WARB_BURST_EN
//   defined   : the owner may keep the port for up to MAX_BURST consecutive
//               beats before rotation (beat counter bcnt_q present).
//   undefined : rotation after every transfer whenever another requester
//               is pending (no beat counter).
//
// "Transfer" means an edge at which wen is high. "req[owner] still set"
// is evaluated on the req value seen at that edge.

module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      wclk,
    input  logic                      wreset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        req_data,
    input  logic                      full,
    output logic [NREQ-1:0]           grant,
    output logic                      wen,
    output logic [DW-1:0]             wdata,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int OW = $clog2(NREQ);
    localparam logic [OW-1:0] OWNER_RST = OW'(NREQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] others;

`ifdef FIFO_WARB_BURST_EN
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
    logic [3:0]      bcnt_q, bcnt_d;
`endif

    // Round-robin search: first set bit of mask scanning last+1, last+2, ...
    // with wrap modulo NREQ. Returns last when mask is empty.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] idx;
        logic          found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(last) + k) % NREQ);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // One-hot view of the owner and the set of competing requesters
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        others            = req & ~owner_oh;
    end

    // Beat acceptance: only the owner, only in GRANT, only while not full
    always_comb begin
        grant = '0;
        if ((state_q == S_GRANT) && req[owner_q] && !full) begin
            grant[owner_q] = 1'b1;
        end
    end

    assign wen = |grant;

    // Write-data mux; forced to zero when no beat is being written
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wen && (owner_q == OW'(i))) begin
                wdata = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state decision for state, owner and beat counter
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef FIFO_WARB_BURST_EN
        bcnt_d  = bcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = rr_pick(req, owner_q);
                    state_d = S_GRANT;
`ifdef FIFO_WARB_BURST_EN
                    bcnt_d  = '0;
`endif
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    // Owner withdrew its request: no transfer, re-pick
                    // among whoever is still asking, otherwise go idle.
                    if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                    end else begin
                        state_d = S_IDLE;
                    end
`ifdef FIFO_WARB_BURST_EN
                    bcnt_d  = '0;
`endif
                end else if (wen) begin
`ifdef FIFO_WARB_BURST_EN
                    if (bcnt_q < BURST_LAST) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                        bcnt_d  = '0;
                    end else begin
                        // Sole requester at the burst limit keeps the port
                        bcnt_d  = '0;
                    end
`else
                    if (|others) begin
                        owner_d = rr_pick(others, owner_q);
                    end
`endif
                end
                // full high with the owner requesting: hold everything
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_GRANT);
    end

    // FSM and registered status outputs
    always_ff @(posedge wclk or negedge wreset) begin
        if (!wreset) begin
            state_q <= S_IDLE;
            owner_q <= OWNER_RST;
            busy_q  <= 1'b0;
`ifdef FIFO_WARB_BURST_EN
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
`ifdef FIFO_WARB_BURST_EN
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed testbench for fifo_write_arbiter (NREQ=4, DW=8, MAX_BURST=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge.

module tb_fifo_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic             wclk = 1'b0;
    logic             wreset;
    logic [NREQ-1:0]  req;
    logic [NREQ*DW-1:0] req_data;
    logic             full;
    logic [NREQ-1:0]  grant;
    logic             wen;
    logic [DW-1:0]    wdata;
    logic [1:0]       owner;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (4)
    ) dut (
        .wclk     (wclk),
        .wreset   (wreset),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .grant    (grant),
        .wen      (wen),
        .wdata    (wdata),
        .owner    (owner),
        .busy     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge wclk);
        #1;
    endtask

    task automatic sample();
        @(negedge wclk);
    endtask

    task automatic do_reset();
        wreset   = 1'b0;
        req      = '0;
        full     = 1'b0;
        req_data = '0;
        next_cycle();
        next_cycle();
        wreset   = 1'b1;
    endtask

    // Full-stall test tables, index = cycle after the IDLE edge
    int fvec [1:8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    int eg4  [1:8] = '{1, 2, 0, 0, 0, 1, 2, 1};
    int ed4  [1:8] = '{'h20, 'h30, 0, 0, 0, 'h21, 'h31, 'h22};

    initial begin
        logic [3:0] prev_g;
        logic [7:0] d0, d1;

        // ---- Reset and idle ----
        wreset = 1'b0; req = '0; full = 1'b0; req_data = '0;
        repeat (2) next_cycle();
        wreset = 1'b1;
        repeat (10) next_cycle();
        sample();
        check_val("idle_grant", 32'(grant), 32'h0);
        check_val("idle_wen",   32'(wen),   32'h0);
        check_val("idle_wdata", 32'(wdata), 32'h0);
        check_val("idle_busy",  32'(busy),  32'h0);
        check_val("idle_owner", 32'(owner), 32'h3);

        // ---- All four requesting: strict rotation ----
        next_cycle();
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        sample();
        check_val("rr_latency_grant", 32'(grant), 32'h0);
        for (int n = 1; n <= 8; n++) begin
            next_cycle();
            sample();
            check_val($sformatf("rr_grant_%0d", n), 32'(grant), 32'(1 << ((n - 1) % 4)));
            check_val($sformatf("rr_wen_%0d", n),   32'(wen),   32'h1);
            check_val($sformatf("rr_wdata_%0d", n), 32'(wdata), 32'('hA0 + (n - 1) % 4));
            check_val($sformatf("rr_busy_%0d", n),  32'(busy),  32'h1);
        end

        // ---- Reset pulsed during a GRANT beat ----
        wreset = 1'b0;
        #1;
        check_val("rst_mid_wen",   32'(wen),   32'h0);
        check_val("rst_mid_busy",  32'(busy),  32'h0);
        check_val("rst_mid_owner", 32'(owner), 32'h3);
        check_val("rst_mid_grant", 32'(grant), 32'h0);
        next_cycle();
        req    = 4'b1010;
        wreset = 1'b1;
        sample();
        check_val("rst_rel_busy", 32'(busy), 32'h0);
        next_cycle();
        sample();
        check_val("rst_rel_grant", 32'(grant), 32'h2);
        check_val("rst_rel_owner", 32'(owner), 32'h1);
        check_val("rst_rel_wdata", 32'(wdata), 32'hA1);

        // ---- Single requester 2, six back-to-back beats ----
        do_reset();
        req      = 4'b0100;
        req_data = 32'h0010_0000;
        sample();
        check_val("solo_idle_busy", 32'(busy), 32'h0);
        for (int b = 0; b < 6; b++) begin
            next_cycle();
            req_data[23:16] = 8'(16 + b);
            sample();
            check_val($sformatf("solo_grant_%0d", b), 32'(grant), 32'h4);
            check_val($sformatf("solo_wen_%0d", b),   32'(wen),   32'h1);
            check_val($sformatf("solo_wdata_%0d", b), 32'(wdata), 32'(16 + b));
        end
        next_cycle();
        req = 4'b0000;
        sample();
        check_val("solo_end_wen", 32'(wen), 32'h0);
        next_cycle();
        sample();
        check_val("solo_end_busy",  32'(busy),  32'h0);
        check_val("solo_end_owner", 32'(owner), 32'h2);

        // ---- Two requesters with full high for three cycles ----
        do_reset();
        d0 = 8'h20;
        d1 = 8'h30;
        req      = 4'b0011;
        req_data = {16'h0, d1, d0};
        sample();
        check_val("full_idle_grant", 32'(grant), 32'h0);
        prev_g = 4'b0;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (prev_g[0]) d0 = d0 + 8'd1;
            if (prev_g[1]) d1 = d1 + 8'd1;
            req_data = {16'h0, d1, d0};
            full     = (fvec[c] != 0);
            sample();
            prev_g = grant;
            check_val($sformatf("full_grant_%0d", c), 32'(grant), 32'(eg4[c]));
            check_val($sformatf("full_wdata_%0d", c), 32'(wdata), 32'(ed4[c]));
            check_val($sformatf("full_wen_%0d", c),   32'(wen),   32'(eg4[c] != 0));
            if (fvec[c] != 0) begin
                check_val($sformatf("full_owner_%0d", c), 32'(owner), 32'h0);
            end
        end

`ifdef FIFO_WARB_BURST_EN
        // ---- Burst mode: 0 and 2 alternate in blocks of four ----
        do_reset();
        req      = 4'b0101;
        req_data = 32'h00C0_00B0;
        sample();
        check_val("burst_idle_grant", 32'(grant), 32'h0);
        for (int n = 1; n <= 12; n++) begin
            next_cycle();
            sample();
            check_val($sformatf("burst_grant_%0d", n), 32'(grant),
                      (((n - 1) / 4) % 2 != 0) ? 32'h4 : 32'h1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
